// File: rtl/chacha_pkg.sv
// Shared constants, FSM encoding and helpers for the ChaCha20 keystream generator.
package chacha_pkg;

    // "expand 32-byte k" as four little-endian words; word 0 is the low slice
    localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    localparam int IDX_CONST = 0;
    localparam int IDX_KEY   = 4;
    localparam int IDX_CTR   = 12;
    localparam int IDX_NONCE = 13;

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, HOLD} state_t;

    function automatic int beat_count(int width);
        return 512 / width;
    endfunction

    function automatic logic [31:0] rotl(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // State-word index of operand pos (a=0..d=3) for quarter-round lane in a column or diagonal round
    function automatic logic [3:0] qidx(int lane, int pos, logic diag);
        return 4'(pos * 4 + (diag ? (lane + pos) % 4 : lane));
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round (rotations 16, 12, 8, 7).
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] a_nxt,
    output logic [31:0] b_nxt,
    output logic [31:0] c_nxt,
    output logic [31:0] d_nxt
);
    logic [31:0] a1, b1, c1, d1;

    assign a1    = a + b;
    assign d1    = rotl(d ^ a1, 16);
    assign c1    = c + d1;
    assign b1    = rotl(b ^ c1, 12);
    assign a_nxt = a1 + b1;
    assign d_nxt = rotl(d1 ^ a_nxt, 8);
    assign c_nxt = c1 + d_nxt;
    assign b_nxt = rotl(b1 ^ c_nxt, 7);
endmodule

// File: rtl/chacha_stream.sv
// Multi-block ChaCha20 keystream generator: iterative round core feeding a
// single-block output buffer that is serialized over a valid/ready stream.
module chacha_stream
    import chacha_pkg::*;
#(
    parameter int ROUND_COUNT = 10,
    parameter int OUT_WIDTH   = 8,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [255:0]         key_i,
    input  logic [95:0]          nonce_i,
    input  logic [31:0]          counter_i,
    input  logic [LEN_WIDTH-1:0] nblocks_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic [OUT_WIDTH-1:0] ks_data_o,
    output logic                 ks_valid_o,
    input  logic                 ks_ready_i,
    output logic                 ks_last_o,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 error_o
);
    localparam int BEATS = beat_count(OUT_WIDTH);
    localparam int IDX_W = $clog2(BEATS);
    localparam logic [4:0] LAST_RND = 5'(2 * ROUND_COUNT - 1);

    state_t state, state_nxt;

    logic [255:0]                      key_q;
    logic [95:0]                       nonce_q;
    logic [31:0]                       ctr_q;
    logic [LEN_WIDTH-1:0]              left_q;
    logic [4:0]                        rnd_q;
    logic [15:0][31:0]                 x_q, x_rnd, init_w, blk;
    logic [BEATS-1:0][OUT_WIDTH-1:0]   buf_q;
    logic                              buf_full, buf_last, buf_err;
    logic [IDX_W-1:0]                  beat_q;

    logic diag, hs, beat_end, buf_free, more, wrap, more_ok, do_start, do_xfer;

    assign diag     = rnd_q[0];
    assign hs       = buf_full & ks_ready_i;
    assign beat_end = beat_q == IDX_W'(BEATS - 1);
    assign buf_free = !buf_full || (hs && beat_end);
    assign more     = left_q > LEN_WIDTH'(1);
    assign wrap     = ctr_q == 32'hffff_ffff;
    assign more_ok  = more && !wrap;

    always_comb begin
        init_w = '0;
        for (int i = 0; i < 4; i++) init_w[IDX_CONST + i] = SIGMA[i];
        for (int i = 0; i < 8; i++) init_w[IDX_KEY + i] = key_q[32*i +: 32];
        init_w[IDX_CTR] = ctr_q;
        for (int i = 0; i < 3; i++) init_w[IDX_NONCE + i] = nonce_q[32*i +: 32];
    end

    always_comb begin
        for (int i = 0; i < 16; i++) blk[i] = x_q[i] + init_w[i];
    end

    logic [31:0] qa [4], qb [4], qc [4], qd [4];
    logic [31:0] ra [4], rb [4], rc [4], rd [4];

    for (genvar i = 0; i < 4; i++) begin : g_qr
        assign qa[i] = x_q[qidx(i, 0, diag)];
        assign qb[i] = x_q[qidx(i, 1, diag)];
        assign qc[i] = x_q[qidx(i, 2, diag)];
        assign qd[i] = x_q[qidx(i, 3, diag)];
        chacha_qr u_qr (
            .a(qa[i]), .b(qb[i]), .c(qc[i]), .d(qd[i]),
            .a_nxt(ra[i]), .b_nxt(rb[i]), .c_nxt(rc[i]), .d_nxt(rd[i])
        );
    end

    always_comb begin
        x_rnd = x_q;
        for (int i = 0; i < 4; i++) begin
            x_rnd[qidx(i, 0, diag)] = ra[i];
            x_rnd[qidx(i, 1, diag)] = rb[i];
            x_rnd[qidx(i, 2, diag)] = rc[i];
            x_rnd[qidx(i, 3, diag)] = rd[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // FINAL and HOLD share the transfer path: the sum x_q + init_w stays valid until copied
    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_xfer   = 1'b0;
        case (state)
            IDLE:  if (start_i && !buf_full) begin do_start = 1'b1; state_nxt = INIT; end
            INIT:  state_nxt = ROUND;
            ROUND: if (rnd_q == LAST_RND) state_nxt = FINAL;
            FINAL, HOLD: begin
                if (buf_free) begin
                    do_xfer   = 1'b1;
                    state_nxt = more_ok ? INIT : IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_i) begin
            state_nxt = IDLE;
            do_start  = 1'b0;
            do_xfer   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q <= '0; nonce_q <= '0; ctr_q <= '0; left_q <= '0;
            rnd_q <= '0; x_q <= '0; buf_q <= '0;
            buf_full <= 1'b0; buf_last <= 1'b0; buf_err <= 1'b0; beat_q <= '0;
            done_o <= 1'b0; error_o <= 1'b0;
        end else begin
            done_o  <= 1'b0;
            error_o <= 1'b0;
            if (do_start) begin
                key_q   <= key_i;
                nonce_q <= nonce_i;
                ctr_q   <= counter_i;
                left_q  <= (nblocks_i == '0) ? LEN_WIDTH'(1) : nblocks_i;
            end
            if (state == INIT) begin
                x_q   <= init_w;
                rnd_q <= '0;
            end else if (state == ROUND) begin
                x_q   <= x_rnd;
                rnd_q <= rnd_q + 5'd1;
            end
            if (hs) begin
                if (beat_end) begin
                    buf_full <= 1'b0;
                    beat_q   <= '0;
                    done_o   <= buf_last & ~buf_err;
                    error_o  <= buf_last & buf_err;
                end else begin
                    beat_q <= beat_q + IDX_W'(1);
                end
            end
            // Overflow: the block just computed is the final one even though more were requested
            if (do_xfer) begin
                buf_q    <= blk;
                buf_full <= 1'b1;
                beat_q   <= '0;
                buf_last <= !more_ok;
                buf_err  <= more && wrap;
                if (more_ok) begin
                    ctr_q  <= ctr_q + 32'd1;
                    left_q <= left_q - LEN_WIDTH'(1);
                end
            end
            if (abort_i) begin
                buf_full <= 1'b0;
                beat_q   <= '0;
                done_o   <= 1'b0;
                error_o  <= 1'b0;
            end
        end
    end

    assign ks_data_o  = buf_q[beat_q];
    assign ks_valid_o = buf_full;
    assign ks_last_o  = buf_full && buf_last && beat_end;
    assign ready_o    = (state == IDLE) && !buf_full;
endmodule

// File: tb/tb_chacha_stream.sv
// Randomized bench for chacha_stream: byte-wise DUT output compared with an RFC 8439 block model.
module tb_chacha_stream;
    localparam int RC = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, abort, rdy, sel;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic [15:0]  nblocks;

    logic [7:0]  d8;  logic v8,  l8,  r8,  dn8,  e8;
    logic [31:0] d32; logic v32, l32, r32, dn32, e32;

    chacha_stream #(.ROUND_COUNT(RC), .OUT_WIDTH(8), .LEN_WIDTH(16)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .key_i(key), .nonce_i(nonce), .counter_i(counter),
        .nblocks_i(nblocks), .start_i(start & ~sel), .abort_i(abort),
        .ks_data_o(d8), .ks_valid_o(v8), .ks_ready_i(rdy & ~sel), .ks_last_o(l8),
        .ready_o(r8), .done_o(dn8), .error_o(e8));

    chacha_stream #(.ROUND_COUNT(RC), .OUT_WIDTH(32), .LEN_WIDTH(16)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .key_i(key), .nonce_i(nonce), .counter_i(counter),
        .nblocks_i(nblocks), .start_i(start & sel), .abort_i(abort),
        .ks_data_o(d32), .ks_valid_o(v32), .ks_ready_i(rdy & sel), .ks_last_o(l32),
        .ready_o(r32), .done_o(dn32), .error_o(e32));

    logic        m_valid, m_last, m_ready, m_done, m_err;
    logic [31:0] m_data;
    assign m_valid = sel ? v32  : v8;
    assign m_last  = sel ? l32  : l8;
    assign m_ready = sel ? r32  : r8;
    assign m_done  = sel ? dn32 : dn8;
    assign m_err   = sel ? e32  : e8;
    assign m_data  = sel ? d32  : {24'h0, d8};

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // RFC 8439 block function; returns the 64 keystream bytes, byte i at [8i+7:8i]
    function automatic logic [511:0] ref_block(logic [255:0] k, logic [95:0] n, logic [31:0] c);
        string       sig = "expand 32-byte k";
        logic [31:0] s [16];
        logic [31:0] x [16];
        int          q [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                                  '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        logic [511:0] o;
        for (int i = 0; i < 4; i++) s[i] = {sig[4*i+3], sig[4*i+2], sig[4*i+1], sig[4*i]};
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int r = 0; r < RC; r++) begin
            for (int j = 0; j < 8; j++) begin
                logic [31:0] a, b, cc, d;
                a = x[q[j][0]]; b = x[q[j][1]]; cc = x[q[j][2]]; d = x[q[j][3]];
                a += b; d = rotl(d ^ a, 16); cc += d; b = rotl(b ^ cc, 12);
                a += b; d = rotl(d ^ a, 8);  cc += d; b = rotl(b ^ cc, 7);
                x[q[j][0]] = a; x[q[j][1]] = b; x[q[j][2]] = cc; x[q[j][3]] = d;
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
        return o;
    endfunction

    logic [7:0] got [$];
    int beats_seen, n_last, last_pos, done_cnt, err_cnt, gaps, stall_bad;
    int first_valid, hs_last_cyc, done_cyc;
    logic rdy_at_done;

    task automatic run(input bit s, input logic [31:0] ctr, input int nblk,
                       input int stall_pct, input int abort_at);
        int w, cyc, waitc;
        bit fin, stalled;
        logic [31:0] hold_d;
        w = s ? 32 : 8;
        got.delete();
        beats_seen = 0; n_last = 0; last_pos = -1; done_cnt = 0; err_cnt = 0;
        gaps = 0; stall_bad = 0; first_valid = -1; hs_last_cyc = -1; done_cyc = -1;
        rdy_at_done = 1'b0; fin = 0; stalled = 0; cyc = 0; hold_d = '0; waitc = 0;
        sel = s;
        rdy = 1'b0;
        @(negedge clk);
        while (!m_ready && waitc < 200) begin @(negedge clk); waitc++; end
        chk("idle_wait", m_ready, 1);
        counter = ctr; nblocks = 16'(nblk); start = 1'b1;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) chk("ready_drop", m_ready, 0);
            if (stalled && (!m_valid || m_data !== hold_d)) stall_bad++;
            if (m_done) begin done_cnt++; done_cyc = cyc; rdy_at_done = m_ready; end
            if (m_err)  begin err_cnt++;  done_cyc = cyc; rdy_at_done = m_ready; end
            if (m_done || m_err) fin = 1;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (!m_valid && first_valid >= 0 && last_pos < 0) gaps++;
            if (abort_at >= 0 && m_valid && beats_seen == abort_at) begin
                abort = 1'b1; start = 1'b1; rdy = 1'b0;
                @(negedge clk);
                abort = 1'b0; start = 1'b0;
                chk("abort_valid", m_valid, 0);
                chk("abort_ready", m_ready, 1);
                for (int i = 0; i < 8; i++) begin
                    if (m_done || m_err) done_cnt++;
                    @(negedge clk);
                end
                fin = 1;
            end else if (!fin) begin
                rdy = ($urandom_range(99) >= stall_pct);
                stalled = m_valid && !rdy;
                hold_d = m_data;
                if (m_valid && rdy) begin
                    for (int b = 0; b < w / 8; b++) got.push_back(m_data[8*b +: 8]);
                    if (m_last) begin n_last++; last_pos = beats_seen; hs_last_cyc = cyc; end
                    beats_seen++;
                end
            end
        end
        chk("run_end", fin, 1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m_done) done_cnt++;
            if (m_err)  err_cnt++;
        end
    endtask

    task automatic verify(input bit s, input logic [31:0] ctr, input int exp_blocks, input bit exp_err);
        int bpb;
        bpb = s ? 16 : 64;
        chk("nbytes", got.size(), 64 * exp_blocks);
        for (int b = 0; b < exp_blocks && 64 * (b + 1) <= got.size(); b++) begin
            logic [511:0] g;
            for (int j = 0; j < 64; j++) g[8*j +: 8] = got[64*b + j];
            chk($sformatf("blk%0d", b), g, ref_block(key, nonce, ctr + 32'(b)));
        end
        chk("n_last", n_last, 1);
        chk("last_pos", last_pos, exp_blocks * bpb - 1);
        chk("done_cnt", done_cnt, exp_err ? 0 : 1);
        chk("err_cnt", err_cnt, exp_err ? 1 : 0);
        chk("end_timing", done_cyc, hs_last_cyc + 1);
        chk("ready_at_end", rdy_at_done, 1);
    endtask

    task automatic set_rfc();
        for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
        nonce = 96'h00000000_4a000000_09000000;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
        for (int i = 0; i < 3; i++) nonce[32*i +: 32] = $urandom;
    endtask

    initial begin
        logic [63:0] first8;
        logic [31:0] rc;
        rst = 1'b1; start = 1'b0; abort = 1'b0; rdy = 1'b0; sel = 1'b0;
        key = '0; nonce = '0; counter = '0; nblocks = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", m_data, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_ready", m_ready, 1);
        chk("rst_done", m_done, 0);
        chk("rst_err", m_err, 0);
        rst = 1'b0;

        // RFC 8439 2.3.2 vector
        set_rfc();
        run(0, 32'd1, 1, 0, -1);
        for (int i = 0; i < 8; i++) first8[8*i +: 8] = (got.size() > i) ? got[i] : 8'h00;
        chk("rfc_first8", first8, 64'h15593bd1_e4e7f110);
        chk("latency", first_valid, 2 * RC + 3);
        verify(0, 32'd1, 1, 0);

        // Multi-block, always ready: gap-free after the first beat
        run(0, 32'd1, 4, 0, -1);
        verify(0, 32'd1, 4, 0);
        chk("gaps", gaps, 0);

        // 32-bit beats with 30% backpressure
        set_rand();
        rc = $urandom;
        run(1, rc, 3, 30, -1);
        verify(1, rc, 3, 0);
        chk("stall_stable", stall_bad, 0);

        // Random runs; nblocks 0 behaves as 1
        for (int t = 0; t < 3; t++) begin
            int nb;
            set_rand();
            rc = $urandom;
            nb = $urandom_range(2);
            run(0, rc, nb, 20, -1);
            verify(0, rc, (nb == 0) ? 1 : nb, 0);
            chk("stall_stable_r", stall_bad, 0);
        end

        // Counter overflow
        set_rand();
        run(0, 32'hffff_fffe, 5, 0, -1);
        verify(0, 32'hffff_fffe, 2, 1);

        // Abort on beat 20 of block 1, then a clean run
        set_rfc();
        run(0, 32'd1, 3, 0, 84);
        chk("abort_no_end", done_cnt, 0);
        chk("abort_bytes", got.size(), 84);
        run(0, 32'd1, 1, 0, -1);
        verify(0, 32'd1, 1, 0);

        // Reset while the second block is in its rounds
        sel = 1'b0; counter = 32'd1; nblocks = 16'd2; start = 1'b1; rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rdy = 1'b0;
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_ready", m_ready, 1);
        chk("mid_rst_done", m_done, 0);
        chk("mid_rst_err", m_err, 0);
        run(0, 32'd1, 1, 0, -1);
        verify(0, 32'd1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
